raster_scheduler: RTL and testbench

Front-end sequencer for the sphere rasterizer. Collects projected sphere records (x, y, depth, radius as 16-bit floats) from NUM_REQ projection units through a round-robin arbiter into a small FIFO. Issues records one at a time to the rasterizer, waiting for it to report idle between issues. Tracks per-frame completion so the frame-buffer swap logic knows when every requester's spheres have been drawn.

---
 rtl/raster_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_raster_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_scheduler.sv
// raster_scheduler
// Front-end sequencer for the sphere rasterizer. Projection units offer
// records through a round-robin arbiter into a small FIFO. Records are then
// issued one at a time to the rasterizer, which must report idle between
// issues. Per-frame completion is tracked so that the frame-buffer swap logic
// learns when every requester's spheres have been drawn.
//
// Ports
//   clk_in, rst_in           clock, asynchronous active-low reset
//   frame_start_in           pulse: clear done flags/issue count, arm frame_done
//   req_valid_in/_data_in    per-requester record offer (64-bit slice each)
//   req_done_in              pulse: requester has no more records this frame
//   req_ready_out            one-hot accept (zero when the FIFO is full)
//   rast_ready_in            rasterizer idle
//   rast_valid_out           one-cycle issue strobe
//   f_*_out                  issued record fields, held until the next issue
//   issued_count_out         saturating issue count for the current frame
//   frame_done_out           one-cycle frame completion pulse
//   busy_out                 FIFO non-empty or issue engine active
module raster_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int HOLDOFF    = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   frame_start_in,
  input  logic [NUM_REQ-1:0]     req_valid_in,
  input  logic [64*NUM_REQ-1:0]  req_data_in,
  input  logic [NUM_REQ-1:0]     req_done_in,
  output logic [NUM_REQ-1:0]     req_ready_out,
  input  logic                   rast_ready_in,
  output logic                   rast_valid_out,
  output logic [15:0]            f_center_x_pos_out,
  output logic [15:0]            f_center_y_pos_out,
  output logic [15:0]            f_center_depth_out,
  output logic [15:0]            f_radius_out,
  output logic [15:0]            issued_count_out,
  output logic                   frame_done_out,
  output logic                   busy_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int HW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e             state_q;
  logic [HW-1:0]      hold_cnt_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [NUM_REQ-1:0] done_q;
  logic               armed_q;
  logic [63:0]        fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic               rast_valid_q;
  logic [63:0]        rec_q;
  logic [15:0]        issued_q;
  logic               frame_done_q;
  logic               busy_q;

  logic [63:0]        slice_s [NUM_REQ];
  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   grant_idx_s;
  logic [PTR_W-1:0]   sel_s;
  logic               found_s;
  logic [63:0]        push_data_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic               start_issue_s;
  logic               next_idle_s;
  logic               done_cond_s;
  logic [63:0]        head_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice_s[g] = req_data_in[g*64 +: 64];
  end

  // Fullness uses the registered count only, so a pop in this cycle never
  // frees a slot for a push in the same cycle.
  assign full_s        = (count_q == CW'(FIFO_DEPTH));
  assign push_s        = |grant_s;
  assign pop_s         = (state_q == S_ISSUE);
  assign count_d       = count_q + CW'(push_s) - CW'(pop_s);
  assign head_s        = fifo_mem_q[rd_ptr_q];
  assign start_issue_s = (state_q == S_IDLE) && (count_q != '0) && rast_ready_in;
  assign next_idle_s   = ((state_q == S_IDLE) && !start_issue_s) ||
                         ((state_q == S_WAIT) && rast_ready_in);
  assign done_cond_s   = armed_q && (&done_q) && (count_q == '0) &&
                         (state_q == S_IDLE) && rast_ready_in;

  // Round-robin grant: first valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    sel_s       = '0;
    found_s     = 1'b0;
    push_data_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_s = PTR_W'((32'(rr_ptr_q) + 32'(k)) % 32'(NUM_REQ));
      if (!found_s && !full_s && req_valid_in[sel_s]) begin
        found_s        = 1'b1;
        grant_s[sel_s] = 1'b1;
        grant_idx_s    = sel_s;
        push_data_s    = slice_s[sel_s];
      end else begin
        found_s = found_s;
      end
    end
  end

  // The grant is forced low while reset is held so every output reads zero.
  assign req_ready_out = grant_s & {NUM_REQ{rst_in}};

  // Record FIFO storage and pointers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q] <= push_data_s;
        wr_ptr_q             <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Arbiter pointer, per-frame done flags and frame completion pulse.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr_q     <= '0;
      done_q       <= '0;
      armed_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (push_s) begin
        rr_ptr_q <= (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + PTR_W'(1);
      end
      // A frame start swallows any done pulse arriving in the same cycle.
      if (frame_start_in) begin
        done_q       <= '0;
        armed_q      <= 1'b1;
        frame_done_q <= 1'b0;
      end else begin
        done_q       <= done_q | req_done_in;
        frame_done_q <= done_cond_s;
        if (done_cond_s) begin
          armed_q <= 1'b0;
        end
      end
    end
  end

  // Issue engine: strobe, data capture, holdoff, then wait for rasterizer idle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      hold_cnt_q   <= '0;
      rast_valid_q <= 1'b0;
      rec_q        <= '0;
      issued_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      // Strobe and data land together on entry to S_ISSUE; the head entry
      // itself is popped at the end of the S_ISSUE cycle.
      rast_valid_q <= start_issue_s;
      if (start_issue_s) begin
        rec_q <= head_s;
      end
      case (state_q)
        S_IDLE: begin
          if (start_issue_s) begin
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          hold_cnt_q <= '0;
          state_q    <= (HOLDOFF == 0) ? S_WAIT : S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt_q == HW'(HOLDOFF - 1)) begin
            state_q <= S_WAIT;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        S_WAIT: begin
          if (rast_ready_in) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      // An issue coinciding with a frame start is counted in the new frame.
      if (frame_start_in) begin
        issued_q <= start_issue_s ? 16'd1 : 16'd0;
      end else if (start_issue_s && (issued_q != 16'hFFFF)) begin
        issued_q <= issued_q + 16'd1;
      end else begin
        issued_q <= issued_q;
      end
      busy_q <= (count_d != '0) || !next_idle_s;
    end
  end

  assign rast_valid_out     = rast_valid_q;
  assign f_center_x_pos_out = rec_q[63:48];
  assign f_center_y_pos_out = rec_q[47:32];
  assign f_center_depth_out = rec_q[31:16];
  assign f_radius_out       = rec_q[15:0];
  assign issued_count_out   = issued_q;
  assign frame_done_out     = frame_done_q;
  assign busy_out           = busy_q;

endmodule

// File: tb/tb_raster_scheduler.sv
module tb_raster_scheduler;

  localparam int NR = 2;
  localparam int FD = 8;
  localparam int HO = 2;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          frame_start;
  logic [NR-1:0] req_valid;
  logic [64*NR-1:0] req_data;
  logic [NR-1:0] req_done;
  logic [NR-1:0] req_ready;
  logic          rast_ready;
  logic          rast_valid;
  logic [15:0]   fx, fy, fdp, fr;
  logic [15:0]   issued;
  logic          frame_done;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  raster_scheduler #(.NUM_REQ(NR), .FIFO_DEPTH(FD), .HOLDOFF(HO)) dut (
    .clk_in             (clk),
    .rst_in             (rst_in),
    .frame_start_in     (frame_start),
    .req_valid_in       (req_valid),
    .req_data_in        (req_data),
    .req_done_in        (req_done),
    .req_ready_out      (req_ready),
    .rast_ready_in      (rast_ready),
    .rast_valid_out     (rast_valid),
    .f_center_x_pos_out (fx),
    .f_center_y_pos_out (fy),
    .f_center_depth_out (fdp),
    .f_radius_out       (fr),
    .issued_count_out   (issued),
    .frame_done_out     (frame_done),
    .busy_out           (busy)
  );

  typedef struct packed {
    logic [1:0] valid;
    logic [1:0] exp_ready;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_rec();
    return {fx, fy, fdp, fr};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst_in = 1'b0; frame_start = 1'b0; req_valid = '0; req_done = '0;
    rast_ready = 1'b0; req_data = '0;
    @(posedge clk); #1;
    rst_in = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] d0, d1, exp_rec, held;
    logic [63:0] exp_q [$];
    int n, n_s, last_s, low;
    int sent [NR];
    bit dsent [NR];
    int n_fd, fd_c, ls, n_str;
    // reference model state
    logic [63:0] mq [$];
    int  m_ptr, m_since, sz, exp_g, idx;
    bit  m_idle, m_strobe, m_fd, m_armed, s_next, idle_next;
    logic [NR-1:0] m_done, exp_ready;
    logic [15:0] m_issued;
    logic [63:0] m_last;
    bit  pend [NR];
    logic [63:0] pdata [NR];

    // arbitration / fill table, rasterizer held busy so nothing drains
    tbl[0]  = '{2'b11, 2'b01, 1'b0};
    tbl[1]  = '{2'b11, 2'b10, 1'b1};
    tbl[2]  = '{2'b11, 2'b01, 1'b1};
    tbl[3]  = '{2'b11, 2'b10, 1'b1};
    tbl[4]  = '{2'b10, 2'b10, 1'b1};
    tbl[5]  = '{2'b10, 2'b10, 1'b1};
    tbl[6]  = '{2'b00, 2'b00, 1'b1};
    tbl[7]  = '{2'b01, 2'b01, 1'b1};
    tbl[8]  = '{2'b01, 2'b01, 1'b1};
    tbl[9]  = '{2'b11, 2'b00, 1'b1};
    tbl[10] = '{2'b01, 2'b00, 1'b1};

    // ---------------- reset state ----------------
    rst_in = 1'b0; frame_start = 1'b0; req_done = '0; rast_ready = 1'b1;
    req_valid = 2'b11; req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_valid", 64'(rast_valid), 64'(0));
    chk("rst_data", out_rec(), 64'(0));
    chk("rst_count", 64'(issued), 64'(0));
    chk("rst_fdone", 64'(frame_done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    req_valid = '0; rst_in = 1'b1;

    // ---------------- latency, then reset during holdoff ----------------
    d0 = 64'h1111_2222_3333_4444;
    d1 = 64'h5555_6666_7777_8888;
    req_data = {d1, d0}; req_valid = 2'b11; rast_ready = 1'b1;
    @(negedge clk);
    chk("lat_grant0", 64'(req_ready), 64'(2'b01));
    @(posedge clk); #1;
    req_valid = 2'b10;
    @(negedge clk);
    chk("lat_grant1", 64'(req_ready), 64'(2'b10));
    chk("lat_early", 64'(rast_valid), 64'(0));
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("lat_strobe", 64'(rast_valid), 64'(1));
    chk("lat_data", out_rec(), d0);
    chk("lat_count", 64'(issued), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_busy", 64'(busy), 64'(1));
    chk("hold_nostrobe", 64'(rast_valid), 64'(0));
    req_valid = 2'b11;
    rst_in = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'(0));
    chk("midrst_valid", 64'(rast_valid), 64'(0));
    chk("midrst_data", out_rec(), 64'(0));
    chk("midrst_count", 64'(issued), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    rst_in = 1'b1; req_valid = '0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rast_valid) n++;
      @(posedge clk); #1;
    end
    chk("midrst_empty", 64'(n), 64'(0));
    chk("midrst_idle", 64'(busy), 64'(0));

    // ---------------- table: round robin and FIFO full ----------------
    do_reset();
    rast_ready = 1'b0;
    for (int r = 0; r < 11; r++) begin
      d0 = {16'h0100 + 16'(2*r), 16'hA000 + 16'(r), 16'hB000 + 16'(r), 16'hC000 + 16'(r)};
      d1 = {16'h0101 + 16'(2*r), 16'hA100 + 16'(r), 16'hB100 + 16'(r), 16'hC100 + 16'(r)};
      req_data  = {d1, d0};
      req_valid = tbl[r].valid;
      @(negedge clk);
      chk($sformatf("tbl_ready[%0d]", r), 64'(req_ready), 64'(tbl[r].exp_ready));
      chk($sformatf("tbl_busy[%0d]", r), 64'(busy), 64'(tbl[r].exp_busy));
      if (tbl[r].exp_ready[0]) exp_q.push_back(d0);
      if (tbl[r].exp_ready[1]) exp_q.push_back(d1);
      @(posedge clk); #1;
    end
    req_valid = '0;

    // ---------------- drain with 5-cycle ready drop after each strobe ----------------
    n_s = 0; last_s = -1; low = 0; held = '0;
    for (int c = 0; c < 200 && n_s < 8; c++) begin
      rast_ready = (low == 0);
      if (low > 0) low--;
      @(negedge clk);
      if (rast_valid) begin
        if (exp_q.size() > 0) exp_rec = exp_q.pop_front();
        else exp_rec = 64'hDEAD_DEAD_DEAD_DEAD;
        chk("drain_data", out_rec(), exp_rec);
        chk("drain_count", 64'(issued), 64'(n_s + 1));
        if (n_s > 0) chk("drain_gap", 64'(c - last_s), 64'(8));
        last_s = c; n_s++; held = exp_rec; low = 5;
      end else begin
        chk("drain_hold", out_rec(), held);
      end
      @(posedge clk); #1;
    end
    chk("drain_total", 64'(n_s), 64'(8));

    // ---------------- frame completion ----------------
    do_reset();
    rast_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin sent[i] = 0; dsent[i] = 1'b0; end
    n_fd = 0; fd_c = -1; ls = -1; n_str = 0;
    for (int c = 0; c < 80; c++) begin
      frame_start = (c == 0);
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = (c >= 1) && (sent[i] < 3);
        req_done[i]  = (sent[i] == 3) && !dsent[i];
        if (req_done[i]) dsent[i] = 1'b1;
      end
      req_data = {48'h0, 16'(16'h0200 + 16'(sent[1])), 48'h0, 16'(16'h0100 + 16'(sent[0]))};
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i] && req_ready[i]) sent[i]++;
      end
      if (rast_valid) begin n_str++; ls = c; end
      if (frame_done) begin n_fd++; fd_c = c; end
      @(posedge clk); #1;
    end
    frame_start = 1'b0; req_done = '0; req_valid = '0;
    chk("frame_count", 64'(issued), 64'(6));
    chk("frame_strobes", 64'(n_str), 64'(6));
    chk("frame_pulses", 64'(n_fd), 64'(1));
    chk("frame_when", 64'(fd_c), 64'(ls + 5));

    // ---------------- frame_start / done collision ----------------
    frame_start = 1'b1; req_done = 2'b01;
    @(posedge clk); #1;
    frame_start = 1'b0; req_done = 2'b10;
    @(posedge clk); #1;
    req_done = '0;
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (frame_done) n++;
      @(posedge clk); #1;
    end
    chk("coll_none", 64'(n), 64'(0));
    req_done = 2'b01;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (frame_done) n++;
      @(posedge clk); #1;
      req_done = '0;
    end
    chk("coll_after", 64'(n), 64'(1));

    // ---------------- randomized run against reference model ----------------
    do_reset();
    m_ptr = 0; m_since = 0; m_idle = 1'b1; m_strobe = 1'b0; m_fd = 1'b0;
    m_armed = 1'b0; m_done = '0; m_issued = '0; m_last = '0;
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; pdata[i] = '0; end
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom_range(2) == 0)) begin
          pend[i]  = 1'b1;
          pdata[i] = {$urandom, $urandom};
        end
        req_valid[i] = pend[i];
        req_data[i*64 +: 64] = pdata[i];
        req_done[i] = ($urandom_range(24) == 0);
      end
      rast_ready  = ($urandom_range(9) < 7);
      frame_start = ($urandom_range(59) == 0);
      @(negedge clk);
      sz = mq.size();
      exp_g = -1;
      if (sz < FD) begin
        for (int k = 0; k < NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (exp_g < 0 && pend[idx]) exp_g = idx;
        end
      end
      exp_ready = (exp_g >= 0) ? NR'(1 << exp_g) : '0;
      if (m_strobe) m_last = mq[0];
      chk("rnd_ready", 64'(req_ready), 64'(exp_ready));
      chk("rnd_valid", 64'(rast_valid), 64'(m_strobe));
      chk("rnd_data", out_rec(), m_last);
      chk("rnd_count", 64'(issued), 64'(m_issued));
      chk("rnd_fdone", 64'(frame_done), 64'(m_fd));
      chk("rnd_busy", 64'(busy), 64'((sz != 0) || !m_idle));
      // advance model one cycle
      s_next    = m_idle && (sz > 0) && rast_ready;
      idle_next = m_idle ? !s_next : ((m_since >= HO + 1) && rast_ready);
      m_since   = s_next ? 0 : m_since + 1;
      if (frame_start) begin
        m_fd = 1'b0; m_armed = 1'b1; m_done = '0;
        m_issued = s_next ? 16'd1 : 16'd0;
      end else begin
        m_fd = m_armed && (&m_done) && (sz == 0) && m_idle && rast_ready;
        if (m_fd) m_armed = 1'b0;
        m_done = m_done | req_done;
        if (s_next && m_issued != 16'hFFFF) m_issued = m_issued + 16'd1;
      end
      if (m_strobe) void'(mq.pop_front());
      if (exp_g >= 0) begin
        mq.push_back(pdata[exp_g]);
        m_ptr = (exp_g + 1) % NR;
        pend[exp_g] = 1'b0;
      end
      m_strobe = s_next;
      m_idle   = idle_next;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
